// File: rtl/mod_mul_scheduler.sv
// rtl/mod_mul_scheduler.sv - round-robin scheduler for a shared pipelined Barrett modular multiplier
// Ports: iClk/iRst clock and asynchronous active-high reset.
//        iReqValid/iReqData0/iReqData1/oReqReady  per-requester operand pairs.
//        oRspValid/oRspData  one-hot result strobe and modular product.
//        iCfgValid/iCfgMod/iCfgK/iCfgU/oCfgReady  modulus parameter load.
//        oMulEn/oMulClr/oMulK/oMulU/oMulMod/oMulData0/oMulData1/iMulData  shared multiplier.
//        oBusy  high while anything is in flight or the scheduler is not in RUN.
module mod_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int LAT     = 7
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [NUM_REQ-1:0]    iReqValid,
  input  logic [NUM_REQ*DW-1:0] iReqData0,
  input  logic [NUM_REQ*DW-1:0] iReqData1,
  output logic [NUM_REQ-1:0]    oReqReady,
  output logic [NUM_REQ-1:0]    oRspValid,
  output logic [DW-1:0]         oRspData,
  input  logic                  iCfgValid,
  input  logic [DW-1:0]         iCfgMod,
  input  logic [5:0]            iCfgK,
  input  logic [2*DW-1:0]       iCfgU,
  output logic                  oCfgReady,
  output logic                  oMulEn,
  output logic                  oMulClr,
  output logic [5:0]            oMulK,
  output logic [2*DW-1:0]       oMulU,
  output logic [DW-1:0]         oMulMod,
  output logic [DW-1:0]         oMulData0,
  output logic [DW-1:0]         oMulData1,
  input  logic [DW-1:0]         iMulData,
  output logic                  oBusy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN, LOAD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   mod_q, mod_d;
  logic [5:0]      k_q, k_d;
  logic [2*DW-1:0] u_q, u_d;
  logic [LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [IW-1:0]   tag_idx_q [LAT];
  logic [IW-1:0]   tag_idx_d [LAT];

  logic            grant_allowed;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand_idx;
  int              cand;

  // A pending config request blocks new grants so the pipeline can drain.
  assign grant_allowed = (state_q == RUN) && !iCfgValid;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!gnt_vld && grant_allowed && iReqValid[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    oReqReady = '0;
    oMulData0 = '0;
    oMulData1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == IW'(i))) begin
        oReqReady[i] = 1'b1;
        oMulData0    = iReqData0[i*DW +: DW];
        oMulData1    = iReqData1[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Tag pipeline mirrors the multiplier latency so results can be routed back.
  always_comb begin
    tag_vld_d[0] = gnt_vld;
    tag_idx_d[0] = gnt_idx;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    k_d     = k_q;
    u_d     = u_q;
    case (state_q)
      UNCFG: if (iCfgValid) state_d = LOAD;
      RUN:   if (iCfgValid) state_d = DRAIN;
      DRAIN: if (tag_vld_q == '0) state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        mod_d   = iCfgMod;
        k_d     = iCfgK;
        u_d     = iCfgU;
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= UNCFG;
      ptr_q     <= '0;
      mod_q     <= '0;
      k_q       <= '0;
      u_q       <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mod_q     <= mod_d;
      k_q       <= k_d;
      u_q       <= u_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < LAT; i++) tag_idx_q[i] <= tag_idx_d[i];
    end
  end

  always_comb begin
    oRspValid = '0;
    if (tag_vld_q[LAT-1]) oRspValid[tag_idx_q[LAT-1]] = 1'b1;
  end

  assign oRspData  = tag_vld_q[LAT-1] ? iMulData : '0;
  assign oCfgReady = (state_q == LOAD);
  // The multiplier is held cleared during reset and flushed on every parameter load.
  assign oMulClr   = iRst | (state_q == LOAD);
  assign oMulEn    = ~iRst;
  assign oMulMod   = mod_q;
  assign oMulK     = k_q;
  assign oMulU     = u_q;
  assign oBusy     = (state_q != RUN) || (tag_vld_q != '0);

endmodule

// File: tb/tb_mod_mul_scheduler.sv
// tb/tb_mod_mul_scheduler.sv - self-checking bench for mod_mul_scheduler
module tb_mod_mul_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int LAT     = 7;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    longint        due;
  } exp_t;

  logic                  iClk;
  logic                  iRst;
  logic [NUM_REQ-1:0]    iReqValid;
  logic [NUM_REQ*DW-1:0] iReqData0;
  logic [NUM_REQ*DW-1:0] iReqData1;
  logic [NUM_REQ-1:0]    oReqReady;
  logic [NUM_REQ-1:0]    oRspValid;
  logic [DW-1:0]         oRspData;
  logic                  iCfgValid;
  logic [DW-1:0]         iCfgMod;
  logic [5:0]            iCfgK;
  logic [2*DW-1:0]       iCfgU;
  logic                  oCfgReady;
  logic                  oMulEn;
  logic                  oMulClr;
  logic [5:0]            oMulK;
  logic [2*DW-1:0]       oMulU;
  logic [DW-1:0]         oMulMod;
  logic [DW-1:0]         oMulData0;
  logic [DW-1:0]         oMulData1;
  logic [DW-1:0]         iMulData;
  logic                  oBusy;

  logic [DW-1:0] a_op [NUM_REQ];
  logic [DW-1:0] b_op [NUM_REQ];
  logic [DW-1:0] mpipe [LAT];
  logic [DW-1:0] cur_mod = '0;
  int            exp_ptr = 0;
  int            checks = 0;
  int            failures = 0;
  longint        cyc = 0;
  exp_t          sbq[$];

  logic [NUM_REQ-1:0] mon_xfer;
  int                 mon_idx;
  exp_t               mon_e;

  mod_mul_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .LAT(LAT)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .iReqData0(iReqData0), .iReqData1(iReqData1), .oReqReady(oReqReady),
    .oRspValid(oRspValid), .oRspData(oRspData),
    .iCfgValid(iCfgValid), .iCfgMod(iCfgMod), .iCfgK(iCfgK), .iCfgU(iCfgU), .oCfgReady(oCfgReady),
    .oMulEn(oMulEn), .oMulClr(oMulClr), .oMulK(oMulK), .oMulU(oMulU), .oMulMod(oMulMod),
    .oMulData0(oMulData0), .oMulData1(oMulData1), .iMulData(iMulData), .oBusy(oBusy)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  always_comb begin
    iReqData0 = '0;
    iReqData1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iReqData0[i*DW +: DW] = a_op[i];
      iReqData1[i*DW +: DW] = b_op[i];
    end
  end

  function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] m);
    logic [2*DW-1:0] p;
    if (m == '0) return '0;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return DW'(p % {{DW{1'b0}}, m});
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int e);
    if (e < 0) return '0;
    return NUM_REQ'(1) << e;
  endfunction

  // Behavioural stand-in for the shared multiplier: fixed latency, clear on oMulClr.
  always @(posedge iClk) begin
    if (oMulClr) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mulmod(oMulData0, oMulData1, oMulMod);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign iMulData = mpipe[LAT-1];

  // Scoreboard: record transfers, match responses by order, target and cycle.
  always @(negedge iClk) begin
    mon_xfer = iReqValid & oReqReady;
    checks++;
    if ($countones(oReqReady) > 1) begin
      failures++;
      $display("FAIL ready_onehot: oReqReady=%b required at most one bit", oReqReady);
    end
    if (mon_xfer != '0) begin
      mon_idx = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (mon_xfer[i]) mon_idx = i;
      checks++;
      if (oMulData0 !== a_op[mon_idx] || oMulData1 !== b_op[mon_idx]) begin
        failures++;
        $display("FAIL mul_operands: got %0h,%0h required %0h,%0h", oMulData0, oMulData1,
                 a_op[mon_idx], b_op[mon_idx]);
      end
      sbq.push_back('{mon_idx, mulmod(a_op[mon_idx], b_op[mon_idx], cur_mod), cyc + LAT});
    end else begin
      checks++;
      if (oMulData0 !== '0 || oMulData1 !== '0) begin
        failures++;
        $display("FAIL mul_operands_idle: got %0h,%0h required 0,0", oMulData0, oMulData1);
      end
    end
    if (oRspValid !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: oRspValid=%b required 0", oRspValid);
      end else begin
        mon_e = sbq.pop_front();
        if (oRspValid !== onehot(mon_e.idx) || oRspData !== mon_e.data || cyc != mon_e.due) begin
          failures++;
          $display("FAIL rsp_match: got valid=%b data=%0h cycle=%0d required valid=%b data=%0h cycle=%0d",
                   oRspValid, oRspData, cyc, onehot(mon_e.idx), mon_e.data, mon_e.due);
        end
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      checks++;
      failures++;
      mon_e = sbq.pop_front();
      $display("FAIL rsp_missing: no response at cycle %0d required requester %0d data %0h",
               cyc, mon_e.idx, mon_e.data);
    end
  end

  task automatic wait_drain();
    for (int n = 0; n < 4 * LAT && sbq.size() != 0; n++) @(negedge iClk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive_cycle(input logic [NUM_REQ-1:0] v, input logic [DW-1:0] lim, input string name);
    int e;
    @(posedge iClk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = $urandom_range(0, int'(lim));
      b_op[i] = $urandom_range(0, int'(lim));
    end
    iReqValid = v;
    @(negedge iClk);
    e = rr_pick(iReqValid, exp_ptr);
    checks++;
    if (oReqReady !== onehot(e)) begin
      failures++;
      $display("FAIL %s_grant: oReqReady=%b required %b", name, oReqReady, onehot(e));
    end
    if (e >= 0) exp_ptr = (e + 1) % NUM_REQ;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    iReqValid = '1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (oBusy !== 1'b1 || oMulClr !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_clr: busy=%b clr=%b required 1,1", oBusy, oMulClr);
    end
    checks++;
    if (oReqReady !== '0 || oRspValid !== '0 || oCfgReady !== 1'b0 || oMulEn !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b cfgrdy=%b en=%b required all 0",
               oReqReady, oRspValid, oCfgReady, oMulEn);
    end
    checks++;
    if (oMulMod !== '0 || oMulK !== '0 || oMulU !== '0 || oRspData !== '0) begin
      failures++;
      $display("FAIL reset_cfg: mod=%0h k=%0h u=%0h data=%0h required 0", oMulMod, oMulK, oMulU, oRspData);
    end
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      checks++;
      if (oReqReady !== '0) begin
        failures++;
        $display("FAIL uncfg_no_grant: oReqReady=%b required 0", oReqReady);
      end
    end
    checks++;
    if (oMulEn !== 1'b1 || oBusy !== 1'b1 || oMulClr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: en=%b busy=%b clr=%b required 1,1,0", oMulEn, oBusy, oMulClr);
    end
    iReqValid = '0;
    exp_ptr = 0;
  endtask

  task automatic test_config(input logic [DW-1:0] m, input logic [5:0] k, input logic [2*DW-1:0] u,
                             input logic [NUM_REQ-1:0] req);
    bit seen;
    int e;
    @(posedge iClk);
    #1;
    iCfgValid = 1'b1;
    iCfgMod   = ~m;
    iCfgK     = ~k;
    iCfgU     = ~u;
    iReqValid = req;
    seen = 0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge iClk);
      checks++;
      if (oReqReady !== '0) begin
        failures++;
        $display("FAIL cfg_blocks_grant: oReqReady=%b required 0", oReqReady);
      end
      if (oCfgReady === 1'b1) begin
        seen = 1;
        checks++;
        if (oMulClr !== 1'b1 || sbq.size() != 0) begin
          failures++;
          $display("FAIL cfg_load: clr=%b outstanding=%0d required 1,0", oMulClr, sbq.size());
        end
      end else begin
        @(posedge iClk);
        #1;
        iCfgMod = m;
        iCfgK   = k;
        iCfgU   = u;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL cfg_timeout: oCfgReady never pulsed required one pulse");
    end
    @(posedge iClk);
    #1;
    iCfgValid = 1'b0;
    iCfgMod   = '0;
    iCfgK     = '0;
    iCfgU     = '0;
    cur_mod   = m;
    @(negedge iClk);
    checks++;
    if (oCfgReady !== 1'b0 || oMulMod !== m || oMulK !== k || oMulU !== u) begin
      failures++;
      $display("FAIL cfg_regs: rdy=%b mod=%0h k=%0d u=%0h required 0,%0h,%0d,%0h",
               oCfgReady, oMulMod, oMulK, oMulU, m, k, u);
    end
    e = rr_pick(iReqValid, exp_ptr);
    checks++;
    if (oReqReady !== onehot(e)) begin
      failures++;
      $display("FAIL cfg_first_grant: oReqReady=%b required %b", oReqReady, onehot(e));
    end
    if (e >= 0) exp_ptr = (e + 1) % NUM_REQ;
    if (req == '0) begin
      checks++;
      if (oBusy !== 1'b0) begin
        failures++;
        $display("FAIL idle_busy: oBusy=%b required 0", oBusy);
      end
    end
  endtask

  task automatic test_single();
    longint t0;
    bit got;
    a_op[0] = 32'd1467;
    b_op[0] = 32'd2489;
    @(posedge iClk);
    #1;
    iReqValid = 4'b0001;
    @(negedge iClk);
    t0 = cyc;
    checks++;
    if (oReqReady !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: oReqReady=%b required 0001", oReqReady);
    end
    exp_ptr = 1;
    @(posedge iClk);
    #1;
    iReqValid = '0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge iClk);
      if (oRspValid !== '0) begin
        got = 1;
        checks++;
        if (oRspValid !== 4'b0001 || oRspData !== 32'd2888) begin
          failures++;
          $display("FAIL single_rsp: valid=%b data=%0d required 0001,2888", oRspValid, oRspData);
        end
        checks++;
        if (cyc - t0 != 7) begin
          failures++;
          $display("FAIL single_latency: %0d cycles required 7", cyc - t0);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL single_timeout: no response required one");
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) drive_cycle('1, 32'd7680, "rr");
    @(posedge iClk);
    #1;
    iReqValid = '0;
    wait_drain();
  endtask

  task automatic test_drain();
    for (int c = 0; c < 5; c++) drive_cycle('1, 32'd7680, "drain_pre");
    test_config(32'd12289, 6'd14, 64'd21843, '1);
    for (int c = 0; c < 4; c++) drive_cycle('1, 32'd12288, "drain_post");
    @(posedge iClk);
    #1;
    iReqValid = '0;
    wait_drain();
  endtask

  task automatic test_cfg_wins();
    a_op[2] = 32'd1234;
    b_op[2] = 32'd5678;
    test_config(32'd7681, 6'd13, 64'd8736, 4'b0100);
    @(posedge iClk);
    #1;
    iReqValid = '0;
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    for (int c = 0; c < 3; c++) drive_cycle('1, 32'd7680, "rst_pre");
    @(posedge iClk);
    #1;
    iReqValid = '0;
    #2;
    iRst = 1'b1;
    #1;
    checks++;
    if (oBusy !== 1'b1 || oMulClr !== 1'b1 || oMulEn !== 1'b0 || oRspValid !== '0 || oMulMod !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b clr=%b en=%b rsp=%b mod=%0h required 1,1,0,0,0",
               oBusy, oMulClr, oMulEn, oRspValid, oMulMod);
    end
    sbq.delete();
    cur_mod = '0;
    exp_ptr = 0;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    iReqValid = '1;
    for (int n = 0; n < 12; n++) begin
      @(negedge iClk);
      checks++;
      if (oReqReady !== '0) begin
        failures++;
        $display("FAIL rst_uncfg_block: oReqReady=%b required 0", oReqReady);
      end
    end
    test_config(32'd7681, 6'd13, 64'd8736, '1);
    for (int c = 0; c < 3; c++) drive_cycle('1, 32'd7680, "rst_post");
    @(posedge iClk);
    #1;
    iReqValid = '0;
    wait_drain();
  endtask

  task automatic test_mersenne();
    int e;
    test_config(32'hFFFF_FFFF, 6'd32, 64'h0000_0001_0000_0001, '0);
    for (int c = 0; c < 24; c++) begin
      @(posedge iClk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        a_op[i] = $urandom;
        b_op[i] = $urandom;
        if (c == 0) a_op[i] = 32'hFFFF_FFFF;
        if (c == 1) begin
          a_op[i] = 32'hFFFF_FFFE;
          b_op[i] = 32'hFFFF_FFFE;
        end
        if (c == 2) a_op[i] = '0;
      end
      iReqValid = '1;
      @(negedge iClk);
      e = rr_pick(iReqValid, exp_ptr);
      checks++;
      if (oReqReady !== onehot(e)) begin
        failures++;
        $display("FAIL mersenne_grant: oReqReady=%b required %b", oReqReady, onehot(e));
      end
      if (e >= 0) exp_ptr = (e + 1) % NUM_REQ;
    end
    @(posedge iClk);
    #1;
    iReqValid = '0;
    wait_drain();
  endtask

  initial begin
    iRst = 1'b1;
    iReqValid = '0;
    iCfgValid = 1'b0;
    iCfgMod = '0;
    iCfgK = '0;
    iCfgU = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    test_reset();
    test_config(32'd7681, 6'd13, 64'd8736, '0);
    test_single();
    test_round_robin();
    test_drain();
    test_cfg_wins();
    test_reset_inflight();
    test_mersenne();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
